// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared pipeline definitions for the forwarding/hazard unit: operand select
// encodings, hazard FSM states and bubble-counter helpers.
package forwarding_hazard_unit_pkg;

   localparam int unsigned SEL_W  = 2;
   localparam int unsigned BCNT_W = 2;

   typedef logic [SEL_W-1:0] sel_t;

   localparam sel_t SEL_RF  = 2'b00;
   localparam sel_t SEL_MEM = 2'b01;
   localparam sel_t SEL_WB  = 2'b10;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } fhu_state_e;

   // Counter preload on entering BUBBLE: the RUN cycle itself is the first bubble.
   function automatic logic [BCNT_W-1:0] bubble_init(input int unsigned load_bubbles);
      return (load_bubbles > 1) ? BCNT_W'(load_bubbles - 2) : '0;
   endfunction

endpackage

// File: rtl/forwarding_hazard_unit_fwd_sel.sv
// Per-operand bypass select and stage-match detection for one source operand.
module fwd_sel
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int unsigned REG_W = 4
) (
   input  logic             forward_en,
   input  logic [REG_W-1:0] src,
   input  logic             src_vld,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   input  logic [REG_W-1:0] wb_dest,
   input  logic             wb_wb_en,
   output sel_t             sel_c,
   output logic             exe_hit_c,
   output logic             mem_hit_c
);

   logic wb_hit_c;

   // MEM is the younger producer, so it wins over WB when both match.
   always_comb begin
      exe_hit_c = src_vld && exe_wb_en && (exe_dest == src);
      mem_hit_c = src_vld && mem_wb_en && (mem_dest == src);
      wb_hit_c  = src_vld && wb_wb_en  && (wb_dest  == src);
      sel_c     = SEL_RF;
      if (forward_en) begin
         if (mem_hit_c) begin
            sel_c = SEL_MEM;
         end else if (wb_hit_c) begin
            sel_c = SEL_WB;
         end
      end
   end

endmodule

// File: rtl/forwarding_hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear that overrides increment.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Pipeline forwarding selects, load-use / no-forward hazard detection with a
// multi-cycle bubble FSM, memory freeze, and stall/forward performance counters.
module forwarding_hazard_unit
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int unsigned REG_W        = 4,
   parameter int unsigned NUM_SRC      = 2,
   parameter int unsigned LOAD_BUBBLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     forward_en,
   input  logic [NUM_SRC*REG_W-1:0] src,
   input  logic [NUM_SRC-1:0]       src_vld,
   input  logic [REG_W-1:0]         exe_dest,
   input  logic [REG_W-1:0]         mem_dest,
   input  logic [REG_W-1:0]         wb_dest,
   input  logic                     exe_wb_en,
   input  logic                     mem_wb_en,
   input  logic                     wb_wb_en,
   input  logic                     exe_mem_r_en,
   input  logic                     mem_ready,
   input  logic                     clr_cnt,
   output logic [NUM_SRC*SEL_W-1:0] sel_src,
   output logic                     hazard,
   output logic                     freeze,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         fwd_cnt
);

   localparam logic [BCNT_W-1:0] BUB_INIT  = bubble_init(LOAD_BUBBLES);
   localparam logic              MULTI_BUB = (LOAD_BUBBLES > 1);

   logic [NUM_SRC-1:0] exe_hit_c;
   logic [NUM_SRC-1:0] mem_hit_c;
   logic               load_use_c;
   logic               no_fwd_c;

   fhu_state_e        state_q, state_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_sel #(
         .REG_W (REG_W)
      ) u_fwd_sel (
         .forward_en (forward_en),
         .src        (src[i*REG_W +: REG_W]),
         .src_vld    (src_vld[i]),
         .exe_dest   (exe_dest),
         .exe_wb_en  (exe_wb_en),
         .mem_dest   (mem_dest),
         .mem_wb_en  (mem_wb_en),
         .wb_dest    (wb_dest),
         .wb_wb_en   (wb_wb_en),
         .sel_c      (sel_src[i*SEL_W +: SEL_W]),
         .exe_hit_c  (exe_hit_c[i]),
         .mem_hit_c  (mem_hit_c[i])
      );
   end

   // Without bypass any in-flight producer of a read operand must drain first.
   always_comb begin
      load_use_c = forward_en && exe_mem_r_en && (|exe_hit_c);
      no_fwd_c   = !forward_en && ((|exe_hit_c) || (|mem_hit_c));
   end

   assign freeze = !mem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // A frozen pipeline (mem_ready=0) holds state and bubble count.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      hazard  = 1'b0;
      case (state_q)
         ST_RUN: begin
            hazard = load_use_c || no_fwd_c;
            if (load_use_c && MULTI_BUB && mem_ready) begin
               state_d = ST_BUBBLE;
               bcnt_d  = BUB_INIT;
            end
         end
         ST_BUBBLE: begin
            hazard = 1'b1;
            if (mem_ready) begin
               if (bcnt_q == '0) begin
                  state_d = ST_RUN;
               end else begin
                  bcnt_d = bcnt_q - BCNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_RUN;
            bcnt_d  = '0;
         end
      endcase
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (hazard || freeze),
      .count (stall_cnt)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_fwd_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (|sel_src),
      .count (fwd_cnt)
   );

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit (REG_W=4, NUM_SRC=2, LOAD_BUBBLES=3, CNT_W=4).
module tb_forwarding_hazard_unit;

   localparam int unsigned REG_W   = 4;
   localparam int unsigned NUM_SRC = 2;
   localparam int unsigned CNT_W   = 4;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     forward_en;
   logic [NUM_SRC*REG_W-1:0] src;
   logic [NUM_SRC-1:0]       src_vld;
   logic [REG_W-1:0]         exe_dest, mem_dest, wb_dest;
   logic                     exe_wb_en, mem_wb_en, wb_wb_en;
   logic                     exe_mem_r_en, mem_ready, clr_cnt;
   logic [2*NUM_SRC-1:0]     sel_src;
   logic                     hazard, freeze;
   logic [CNT_W-1:0]         stall_cnt, fwd_cnt;

   int n_checks = 0;
   int n_errors = 0;

   forwarding_hazard_unit #(
      .REG_W        (REG_W),
      .NUM_SRC      (NUM_SRC),
      .LOAD_BUBBLES (3),
      .CNT_W        (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .forward_en   (forward_en),
      .src          (src),
      .src_vld      (src_vld),
      .exe_dest     (exe_dest),
      .mem_dest     (mem_dest),
      .wb_dest      (wb_dest),
      .exe_wb_en    (exe_wb_en),
      .mem_wb_en    (mem_wb_en),
      .wb_wb_en     (wb_wb_en),
      .exe_mem_r_en (exe_mem_r_en),
      .mem_ready    (mem_ready),
      .clr_cnt      (clr_cnt),
      .sel_src      (sel_src),
      .hazard       (hazard),
      .freeze       (freeze),
      .stall_cnt    (stall_cnt),
      .fwd_cnt      (fwd_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      forward_en   = 1'b1;
      src          = '0;
      src_vld      = '0;
      exe_dest     = '0;
      mem_dest     = '0;
      wb_dest      = '0;
      exe_wb_en    = 1'b0;
      mem_wb_en    = 1'b0;
      wb_wb_en     = 1'b0;
      exe_mem_r_en = 1'b0;
      mem_ready    = 1'b1;
      clr_cnt      = 1'b0;
   endtask

   task automatic clear_counters();
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
   endtask

   task automatic set_load_use();
      forward_en   = 1'b1;
      exe_dest     = 4'd5;
      exe_wb_en    = 1'b1;
      exe_mem_r_en = 1'b1;
      src          = {4'd5, 4'd0};
      src_vld      = 2'b10;
   endtask

   task automatic drop_exe();
      exe_wb_en    = 1'b0;
      exe_mem_r_en = 1'b0;
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #1;
      chk("reset_hazard", 32'(hazard), 32'd0);
      chk("reset_freeze", 32'(freeze), 32'd0);
      chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("reset_fwd_cnt", 32'(fwd_cnt), 32'd0);
      chk("reset_sel", 32'(sel_src), 32'd0);
      #3 rst_n = 1'b1;
      tick();

      // Forwarding selects, MEM priority over WB
      src = {4'd0, 4'd3}; src_vld = 2'b01;
      mem_dest = 4'd3; mem_wb_en = 1'b1; wb_dest = 4'd3; wb_wb_en = 1'b1;
      #1;
      chk("sel_mem_prio", 32'(sel_src), 32'h1);
      chk("sel_mem_prio_hazard", 32'(hazard), 32'd0);
      mem_wb_en = 1'b0; #1;
      chk("sel_wb_only", 32'(sel_src), 32'h2);
      src = {4'd7, 4'd3}; src_vld = 2'b11; mem_dest = 4'd7; mem_wb_en = 1'b1; #1;
      chk("sel_two_ops", 32'(sel_src), 32'h6);
      src_vld = 2'b10; #1;
      chk("sel_op0_invalid", 32'(sel_src), 32'h4);
      src_vld = 2'b00; #1;
      chk("sel_none_valid", 32'(sel_src), 32'h0);
      src_vld = 2'b11; exe_dest = 4'd7; exe_wb_en = 1'b1; #1;
      chk("exe_alu_forwardable", 32'(hazard), 32'd0);

      // Stall-only mode
      clear_inputs();
      forward_en = 1'b0; src = {4'd0, 4'd2}; src_vld = 2'b01;
      mem_dest = 4'd2; mem_wb_en = 1'b1; #1;
      chk("nofwd_mem_hazard", 32'(hazard), 32'd1);
      chk("nofwd_mem_sel", 32'(sel_src), 32'h0);
      mem_wb_en = 1'b0; wb_dest = 4'd2; wb_wb_en = 1'b1; #1;
      chk("nofwd_wb_only", 32'(hazard), 32'd0);
      wb_wb_en = 1'b0; exe_dest = 4'd2; exe_wb_en = 1'b1; #1;
      chk("nofwd_exe_hazard", 32'(hazard), 32'd1);
      src_vld = 2'b00; #1;
      chk("nofwd_invalid_src", 32'(hazard), 32'd0);

      // Forward counter
      clear_inputs();
      clear_counters();
      chk("cnt_clear_stall", 32'(stall_cnt), 32'd0);
      chk("cnt_clear_fwd", 32'(fwd_cnt), 32'd0);
      src = {4'd0, 4'd3}; src_vld = 2'b01; mem_dest = 4'd3; mem_wb_en = 1'b1;
      tick(); tick(); tick();
      chk("fwd_cnt_3", 32'(fwd_cnt), 32'd3);
      chk("fwd_stall_cnt_0", 32'(stall_cnt), 32'd0);

      // Load-use with three bubbles
      clear_inputs();
      clear_counters();
      set_load_use(); #1;
      chk("lu_c1", 32'(hazard), 32'd1);
      tick(); drop_exe(); #1;
      chk("lu_c2", 32'(hazard), 32'd1);
      tick();
      chk("lu_c3", 32'(hazard), 32'd1);
      tick();
      chk("lu_done", 32'(hazard), 32'd0);
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd3);
      chk("lu_fwd_cnt", 32'(fwd_cnt), 32'd0);

      // Load-use with a 2-cycle memory freeze inside BUBBLE
      set_load_use(); #1;
      chk("lufz_c1", 32'(hazard), 32'd1);
      tick(); drop_exe(); mem_ready = 1'b0; #1;
      chk("lufz_c2", 32'(hazard), 32'd1);
      chk("lufz_c2_freeze", 32'(freeze), 32'd1);
      tick();
      chk("lufz_c3", 32'(hazard), 32'd1);
      chk("lufz_c3_freeze", 32'(freeze), 32'd1);
      tick(); mem_ready = 1'b1; #1;
      chk("lufz_c4", 32'(hazard), 32'd1);
      chk("lufz_c4_freeze", 32'(freeze), 32'd0);
      tick();
      chk("lufz_c5", 32'(hazard), 32'd1);
      tick();
      chk("lufz_done", 32'(hazard), 32'd0);
      chk("lufz_stall_cnt", 32'(stall_cnt), 32'd8);

      // Saturation and clear priority
      clear_counters();
      forward_en = 1'b0; src = {4'd0, 4'd2}; src_vld = 2'b01;
      mem_dest = 4'd2; mem_wb_en = 1'b1;
      for (int k = 0; k < 21; k++) tick();
      chk("sat_stall", 32'(stall_cnt), 32'hF);
      chk("sat_hazard_fwd_cnt", 32'(fwd_cnt), 32'd0);
      clr_cnt = 1'b1; tick();
      chk("clr_over_inc", 32'(stall_cnt), 32'd0);
      clr_cnt = 1'b0; tick();
      chk("inc_after_clr", 32'(stall_cnt), 32'd1);
      clear_inputs();
      clear_counters();
      src = {4'd0, 4'd3}; src_vld = 2'b01; mem_dest = 4'd3; mem_wb_en = 1'b1;
      mem_ready = 1'b0;
      for (int k = 0; k < 21; k++) tick();
      chk("sat_freeze_stall", 32'(stall_cnt), 32'hF);
      chk("sat_fwd", 32'(fwd_cnt), 32'hF);

      // Asynchronous reset mid-BUBBLE
      clear_inputs();
      clear_counters();
      set_load_use(); tick(); drop_exe(); tick();
      chk("pre_rst_hazard", 32'(hazard), 32'd1);
      chk("pre_rst_stall", 32'(stall_cnt), 32'd2);
      #2 rst_n = 1'b0; #1;
      chk("rst_mid_bubble_hazard", 32'(hazard), 32'd0);
      chk("rst_mid_bubble_stall", 32'(stall_cnt), 32'd0);
      chk("rst_mid_bubble_fwd", 32'(fwd_cnt), 32'd0);
      forward_en = 1'b0; src = {4'd0, 4'd2}; src_vld = 2'b01;
      mem_dest = 4'd2; mem_wb_en = 1'b1; mem_ready = 1'b0; #1;
      chk("rst_comb_hazard", 32'(hazard), 32'd1);
      chk("rst_comb_freeze", 32'(freeze), 32'd1);
      tick();
      chk("rst_hold_stall", 32'(stall_cnt), 32'd0);
      clear_inputs(); #1;
      rst_n = 1'b1;
      tick();
      chk("post_rst_hazard", 32'(hazard), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
